rca_digit_serial_adder: RTL and testbench

// - Multi-cycle, parametrised ripple-carry adder. Adds two N-bit operands W bits per clock
//   (N/W chunk cycles), with carry held in a register between chunks.
// - Selectable unsigned/signed overflow. Valid/ready handshake on input and output.
// - Successor to the combinational N-bit RCA. Used on wide datapaths where a full-width

---
 rtl/rca_digit_serial_adder.sv | 157 +++++++++++++++
 tb/tb_rca_digit_serial_adder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_digit_serial_adder.sv
// rca_digit_serial_adder
// Digit-serial ripple-carry adder: adds two N-bit operands W bits per clock,
// holding the inter-chunk carry in a register. Handshake:
//   input side  - operands transfer on a rising edge where in_valid & in_ready;
//                 in_ready is high only in IDLE, in_valid is ignored elsewhere.
//   output side - result transfers on a rising edge where out_valid & out_ready;
//                 out_valid and sum/cout/v are held stable until that edge.
// Optional feature: define RCA_SAT_EN to saturate sum on overflow (cout/v still
// report the raw overflow). Without it, sum is always the wrapped result.
// o_dbg_state exposes the FSM state (0=IDLE, 1=BUSY, 2=DONE).
module rca_digit_serial_adder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         v,
    output logic         busy,
    output logic [1:0]   o_dbg_state
);

    localparam int NC = N / W;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Operand width must split into whole chunks.
    generate
        if ((N % W) != 0 || W < 1 || N < 2) begin : g_bad_params
            $error("rca_digit_serial_adder: N must be >= 2 and a multiple of W");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_signed;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_v;

    logic [W-1:0]  w_ca;
    logic [W-1:0]  w_cb;
    logic [W-1:0]  w_cs;
    logic          w_c;
    logic          w_cmsb_in;
    logic          w_chunk_cout;
    logic          w_last;
    logic          w_v;
    logic [N-1:0]  w_sum_next;

    // Bit-level ripple through the current chunk, starting from the carry register.
    always_comb begin
        w_ca      = r_a[r_cnt*W +: W];
        w_cb      = r_b[r_cnt*W +: W];
        w_cs      = '0;
        w_cmsb_in = 1'b0;
        w_c       = r_carry;
        for (int i = 0; i < W; i++) begin
            w_cs[i] = w_ca[i] ^ w_cb[i] ^ w_c;
            if (i == W - 1) begin
                w_cmsb_in = w_c;
            end
            w_c = (w_ca[i] & w_cb[i]) | (w_c & (w_ca[i] ^ w_cb[i]));
        end
        w_chunk_cout = w_c;
    end

    // Merge the chunk into the running sum; on the final chunk form flags
    // (carry into bit N-1 is the carry into the top bit of the last chunk).
    always_comb begin
        w_last     = (r_cnt == CW'(NC - 1));
        w_v        = r_signed ? (w_cmsb_in ^ w_chunk_cout) : w_chunk_cout;
        w_sum_next = r_sum;
        w_sum_next[r_cnt*W +: W] = w_cs;
`ifdef RCA_SAT_EN
        if (w_last && w_v) begin
            if (!r_signed) begin
                w_sum_next = '1;
            end else if (r_a[N-1]) begin
                w_sum_next = {1'b1, {(N-1){1'b0}}};
            end else begin
                w_sum_next = {1'b0, {(N-1){1'b1}}};
            end
        end
`endif
    end

    // FSM and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_mode;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_chunk_cout;
                        r_v     <= w_v;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state == S_BUSY);
    assign out_valid   = (r_state == S_DONE);
    assign sum         = r_sum;
    assign cout        = r_cout;
    assign v           = r_v;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rca_digit_serial_adder.sv
// tb_rca_digit_serial_adder
// Bench for the digit-serial adder: a W=4 main instance plus W=1 and W=16
// instances for the latency-scaling cases. Expected results come from a plain
// arithmetic reference model (optionally saturating when RCA_SAT_EN is defined).
module tb_rca_digit_serial_adder;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int NC = N / W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (W=4) ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         signed_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         cout;
  logic         v;
  logic         busy;
  logic [1:0]   dbg_state;

  rca_digit_serial_adder #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .v(v), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- W=1 and W=16 instances ----------------
  logic         x_ready = 1'b1;
  logic         in_valid_1 = 1'b0;
  logic         in_ready_1, out_valid_1, cout_1, v_1, busy_1;
  logic [N-1:0] sum_1;
  logic [1:0]   dbg_1;
  logic         in_valid_16 = 1'b0;
  logic         in_ready_16, out_valid_16, cout_16, v_16, busy_16;
  logic [N-1:0] sum_16;
  logic [1:0]   dbg_16;

  rca_digit_serial_adder #(.N(N), .W(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .a(a), .b(b), .cin(cin), .signed_mode(signed_mode),
    .out_valid(out_valid_1), .out_ready(x_ready), .sum(sum_1), .cout(cout_1),
    .v(v_1), .busy(busy_1), .o_dbg_state(dbg_1)
  );

  rca_digit_serial_adder #(.N(N), .W(16)) u_dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .a(a), .b(b), .cin(cin), .signed_mode(signed_mode),
    .out_valid(out_valid_16), .out_ready(x_ready), .sum(sum_16), .cout(cout_16),
    .v(v_16), .busy(busy_16), .o_dbg_state(dbg_16)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [N+1:0] exp_q[$];   // {v, cout, sum}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic, overflow judged by result range.
  function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic mc, input logic ms);
    longint ua, ub, us, sa, sb, ss, smax, smin;
    logic [N-1:0] s;
    logic co, ov;
    ua = longint'(ma);
    ub = longint'(mb);
    us = ua + ub + longint'(mc);
    co = (us >= (longint'(1) << N));
    s  = N'(us);
    sa = ma[N-1] ? ua - (longint'(1) << N) : ua;
    sb = mb[N-1] ? ub - (longint'(1) << N) : ub;
    ss = sa + sb + longint'(mc);
    smax = (longint'(1) << (N - 1)) - 1;
    smin = -(longint'(1) << (N - 1));
    ov = ms ? ((ss > smax) || (ss < smin)) : co;
`ifdef RCA_SAT_EN
    if (ov) begin
      if (!ms) s = '1;
      else if (ma[N-1]) s = {1'b1, {(N-1){1'b0}}};
      else s = {1'b0, {(N-1){1'b1}}};
    end
`endif
    return {ov, co, s};
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after an edge with the main DUT idle; returns #1 after the accept edge.
  task automatic start_op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                          input logic xc, input logic xs);
    chk("in_ready_idle", in_ready, 1);
    a = xa; b = xb; cin = xc; signed_mode = xs;
    in_valid = 1'b1;
    exp_q.push_back(model(xa, xb, xc, xs));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("in_ready_busy", in_ready, 0);
  endtask

  // Waits for out_valid, checks latency and the scoreboard head.
  task automatic finish_op();
    int lat;
    logic [N+1:0] e;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", out_valid, 1);
    chk("latency", lat, NC);
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk("sum", sum, e[N-1:0]);
      chk("cout", cout, e[N]);
      chk("v", v, e[N+1]);
    end
  endtask

  task automatic release_op(input int delay);
    repeat (delay) begin
      @(posedge clk); #1;
      chk("out_valid_hold", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  task automatic run_widths(input logic [N-1:0] xa, input logic [N-1:0] xb,
                            input logic xc, input logic xs, input logic [N-1:0] esum);
    int lat1, lat16;
    logic [N+1:0] r1, r16;
    lat1 = -1; lat16 = -1; r1 = '0; r16 = '0;
    a = xa; b = xb; cin = xc; signed_mode = xs;
    in_valid_1 = 1'b1; in_valid_16 = 1'b1;
    @(posedge clk); #1;
    in_valid_1 = 1'b0; in_valid_16 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid_1 && lat1 < 0) begin lat1 = k; r1 = {v_1, cout_1, sum_1}; end
      if (out_valid_16 && lat16 < 0) begin lat16 = k; r16 = {v_16, cout_16, sum_16}; end
    end
    chk("w1_latency", lat1, 16);
    chk("w16_latency", lat16, 1);
    chk("w1_result", r1, {2'b00, esum});
    chk("w16_result", r16, {2'b00, esum});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N-1:0] held;
    logic [N-1:0] ra, rb;

    // reset values
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_v", v, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // unsigned 0xFFFF + 0x0001
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    finish_op();
`ifdef RCA_SAT_EN
    chk("u_ffff_sum", sum, 16'hFFFF);
`else
    chk("u_ffff_sum", sum, 16'h0000);
`endif
    chk("u_ffff_cout", cout, 1);
    chk("u_ffff_v", v, 1);
    release_op(0);

    // signed 0x7FFF + 0x0001
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    finish_op();
`ifdef RCA_SAT_EN
    chk("s_7fff_sum", sum, 16'h7FFF);
`else
    chk("s_7fff_sum", sum, 16'h8000);
`endif
    chk("s_7fff_cout", cout, 0);
    chk("s_7fff_v", v, 1);
    release_op(0);

    // signed 0xFFFF + 0x0001
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    finish_op();
    chk("s_ffff_sum", sum, 16'h0000);
    chk("s_ffff_cout", cout, 1);
    chk("s_ffff_v", v, 0);
    release_op(0);

    // 0x1234 + 0x4321 + 1 in both modes
    for (int m = 0; m < 2; m++) begin
      start_op(16'h1234, 16'h4321, 1'b1, m[0]);
      finish_op();
      chk("mix_sum", sum, 16'h5556);
      chk("mix_flags", {cout, v}, 2'b00);
      release_op(0);
    end

    // same add on W=1 and W=16 instances
    run_widths(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556);

    // backpressure in DONE with new operands offered
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    finish_op();
    held = sum;
    a = 16'hABCD; b = 16'h1111; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum_held", sum, held);
      in_valid = 1'b0;
    end
    release_op(0);
    @(posedge clk); #1;
    chk("bp_no_new_op", busy, 0);
    chk("bp_idle_ready", in_ready, 1);

    // out_ready while idle has no effect
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_ready", {out_valid, busy, in_ready}, 3'b001);

    // reset in the middle of chunk 2
    start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_flags", {cout, v}, 2'b00);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    finish_op();
    chk("post_rst_sum", sum, 16'h0002);
    release_op(0);

    // randomized operations with random output backpressure
    for (int k = 0; k < 24; k++) begin
      ra = N'($urandom_range(0, 16'hFFFF));
      rb = N'($urandom_range(0, 16'hFFFF));
      if (k % 6 == 0) ra = {ra[N-1], {(N-1){~ra[N-1]}}};
      start_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_op();
      release_op($urandom_range(0, 2));
    end

    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
